mc_bus_dispatcher: RTL and testbench
====================================

// Module: mc_bus_dispatcher
// PURPOSE
//  Upstream feeder for one multicaster column group on the global bus: loads a filter kernel
//  (flush pulse, kernel size, weight words), then streams ifmap/psum operand pairs to the
//  addressed column. Arbitrates config vs. activation traffic and honours kernel_busy / ready.
//  Sits between the input staging FIFOs and the bus interface of the multicaster array.
// PARAMETERS
//  DATA_WIDTH  16  ifmap / weight word width; psum is 2*DATA_WIDTH
//  NUM_COL     4   columns on the bus; ID width IDW = $clog2(NUM_COL)+1
//  MAX_KERNEL  16  largest legal kernel_size (weight-buffer depth)
// PORTS
//  clk              in   1        clock
//  rst              in   1        asynchronous, active-high reset
//  s_kcfg_valid     in   1        kernel config request
//  s_kcfg_ready     out  1        config accepted when valid&ready
//  s_kcfg_size      in   8        kernel size (number of weight words)
//  s_kcfg_id        in   IDW      destination column ID
//  s_fltr_valid     in   1        weight word valid
//  s_fltr_ready     out  1        weight word accepted when valid&ready
//  s_fltr_data      in   DW       weight word
//  s_act_valid      in   1        ifmap/psum pair valid
//  s_act_ready      out  1        pair accepted when valid&ready
//  s_act_ifmap      in   DW       ifmap word
//  s_act_psum       in   2*DW     psum word
//  s_act_id         in   IDW      destination column ID for the pair
//  bus_id           out  IDW      registered bus ID
//  bus_flush_kernel out  1        one-cycle kernel flush pulse
//  bus_kernel_size  out  8        kernel size, valid with flush
//  bus_fltr_data    out  DW       weight word
//  bus_fltr_we      out  1        weight word strobe
//  bus_ifmap_data   out  DW       ifmap word
//  bus_psum_data    out  2*DW     psum word
//  bus_data_valid   out  1        ifmap/psum strobe
//  bus_kernel_busy  in   1        target weight buffer still busy
//  bus_ready        in   1        target PE array can take an operand pair
//  kernel_loaded    out  1        a kernel has been fully loaded since reset
//  cfg_err          out  1        sticky: illegal kernel size seen
//  act_count        out  16       accepted pairs since last config, wraps at 2^16
// BEHAVIOUR
//  Reset: state IDLE; all bus_* outputs, kernel_loaded, cfg_err, act_count = 0; all *_ready = 0.
//  Bus outputs are registered: one cycle from input handshake to bus strobe.
//  FSM IDLE -> FLUSH -> LOAD -> WAIT_KB -> IDLE.
//  IDLE: s_kcfg_ready=1. Config has priority: if s_kcfg_valid, s_act_ready=0.
//    cfg accepted, size in 1..MAX_KERNEL: latch size and id, kernel_loaded<=0, act_count<=0, go FLUSH.
//    cfg accepted, size 0 or >MAX_KERNEL: cfg_err<=1, kernel_loaded and act_count unchanged, stay IDLE.
//    s_act_ready = kernel_loaded & bus_ready & ~s_kcfg_valid; on accept, next cycle
//    bus_data_valid=1, bus_id=s_act_id, data registered; act_count+1 (wraps 0xFFFF->0).
//  FLUSH (1 cycle): bus_flush_kernel=1, bus_kernel_size=size, bus_id=cfg id. Go LOAD, wcnt=0.
//  LOAD: s_fltr_ready=1 while wcnt<size; each accepted word -> bus_fltr_we=1 next cycle, wcnt+1.
//    Source bubbles (valid=0) stall without strobes. After word size-1 accepted go WAIT_KB.
//  WAIT_KB: all *_ready=0; when bus_kernel_busy=0 set kernel_loaded=1, go IDLE.
//    Entering WAIT_KB, busy is sampled no earlier than one cycle after the last weight strobe.
//  Strobes (flush, fltr_we, data_valid) are single-cycle pulses, mutually exclusive per cycle;
//    data buses hold their last value when no strobe.
//  rst asserted mid-operation: immediate return to reset values; a partial kernel is discarded
//    (kernel_loaded=0). The multicaster must be re-flushed.
//  bus_ready dropping in the same cycle as s_act_valid: no accept, no strobe; the pair is held upstream.
// TESTING
//  1 cfg size=9 id=2, 9 weights 0x0001..0x0009 -> flush pulse with size 9 id 2, then 9 fltr_we
//    strobes in order; kernel_loaded=1 once busy=0.
//  2 after load, 5 pairs with bus_ready=1 -> 5 consecutive data_valid pulses, 1-cycle latency,
//    act_count=5.
//  3 bus_ready toggled 1010 during stream -> pairs accepted only on ready=1 cycles, none lost
//    or duplicated.
//  4 cfg size=0, then cfg size=20 -> cfg_err=1, no flush pulse, state stays IDLE.
//  5 rst asserted after 4 of 9 weights -> all outputs 0, kernel_loaded=0; pairs refused until
//    a new full load completes.
//  6 kcfg_valid and act_valid in the same IDLE cycle -> config wins, act_ready=0, act_count
//    reset to 0.

Source files
------------

// File: rtl/mc_bus_dispatcher.sv
// Bus feeder for one multicaster column group: loads a kernel (flush, size,
// weights) and then streams ifmap/psum pairs to the addressed column.
module mc_bus_dispatcher #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    parameter  int MAX_KERNEL = 16,
    localparam int IDW        = $clog2(NUM_COL) + 1,
    localparam int DW         = DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_kcfg_valid,
    output logic            s_kcfg_ready,
    input  logic [7:0]      s_kcfg_size,
    input  logic [IDW-1:0]  s_kcfg_id,
    input  logic            s_fltr_valid,
    output logic            s_fltr_ready,
    input  logic [DW-1:0]   s_fltr_data,
    input  logic            s_act_valid,
    output logic            s_act_ready,
    input  logic [DW-1:0]   s_act_ifmap,
    input  logic [2*DW-1:0] s_act_psum,
    input  logic [IDW-1:0]  s_act_id,
    output logic [IDW-1:0]  bus_id,
    output logic            bus_flush_kernel,
    output logic [7:0]      bus_kernel_size,
    output logic [DW-1:0]   bus_fltr_data,
    output logic            bus_fltr_we,
    output logic [DW-1:0]   bus_ifmap_data,
    output logic [2*DW-1:0] bus_psum_data,
    output logic            bus_data_valid,
    input  logic            bus_kernel_busy,
    input  logic            bus_ready,
    output logic            kernel_loaded,
    output logic            cfg_err,
    output logic [15:0]     act_count
);

    typedef enum logic [1:0] {IDLE, FLUSH, LOAD, WAIT_KB} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] size_q;
    logic [7:0] wcnt;
    logic       cfg_ok;
    logic       cfg_hs;
    logic       fltr_hs;
    logic       act_hs;
    logic       kb_done;

    assign cfg_ok  = (s_kcfg_size != 8'd0) && (s_kcfg_size <= 8'(MAX_KERNEL));
    assign cfg_hs  = s_kcfg_valid & s_kcfg_ready;
    assign fltr_hs = s_fltr_valid & s_fltr_ready;
    assign act_hs  = s_act_valid & s_act_ready;
    // The last weight strobe must be off the bus before busy is trusted.
    assign kb_done = ~bus_kernel_busy & ~bus_fltr_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        s_kcfg_ready = 1'b0;
        s_fltr_ready = 1'b0;
        s_act_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                s_kcfg_ready = 1'b1;
                s_act_ready  = kernel_loaded & bus_ready & ~s_kcfg_valid;
                if (s_kcfg_valid && cfg_ok) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                s_fltr_ready = (wcnt < size_q);
                if (s_fltr_valid && s_fltr_ready && (wcnt == size_q - 8'd1)) begin
                    state_nxt = WAIT_KB;
                end
            end
            WAIT_KB: begin
                if (kb_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            s_kcfg_ready = 1'b0;
            s_fltr_ready = 1'b0;
            s_act_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q           <= '0;
            wcnt             <= '0;
            bus_id           <= '0;
            bus_flush_kernel <= 1'b0;
            bus_kernel_size  <= '0;
            bus_fltr_data    <= '0;
            bus_fltr_we      <= 1'b0;
            bus_ifmap_data   <= '0;
            bus_psum_data    <= '0;
            bus_data_valid   <= 1'b0;
            kernel_loaded    <= 1'b0;
            cfg_err          <= 1'b0;
            act_count        <= '0;
        end else begin
            bus_flush_kernel <= 1'b0;
            bus_fltr_we      <= 1'b0;
            bus_data_valid   <= 1'b0;
            if (cfg_hs) begin
                if (cfg_ok) begin
                    size_q           <= s_kcfg_size;
                    bus_flush_kernel <= 1'b1;
                    bus_kernel_size  <= s_kcfg_size;
                    bus_id           <= s_kcfg_id;
                    kernel_loaded    <= 1'b0;
                    act_count        <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (state == FLUSH) begin
                wcnt <= '0;
            end
            if (fltr_hs) begin
                bus_fltr_we   <= 1'b1;
                bus_fltr_data <= s_fltr_data;
                wcnt          <= wcnt + 8'd1;
            end
            if (act_hs) begin
                bus_data_valid <= 1'b1;
                bus_id         <= s_act_id;
                bus_ifmap_data <= s_act_ifmap;
                bus_psum_data  <= s_act_psum;
                act_count      <= act_count + 16'd1;
            end
            if (state == WAIT_KB && kb_done) begin
                kernel_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_bus_dispatcher.sv
// Directed bench for mc_bus_dispatcher: transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_mc_bus_dispatcher;

    localparam int IDW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_kcfg_valid = 1'b0;
    logic            s_kcfg_ready;
    logic [7:0]      s_kcfg_size = '0;
    logic [IDW-1:0]  s_kcfg_id = '0;
    logic            s_fltr_valid = 1'b0;
    logic            s_fltr_ready;
    logic [15:0]     s_fltr_data = '0;
    logic            s_act_valid = 1'b0;
    logic            s_act_ready;
    logic [15:0]     s_act_ifmap = '0;
    logic [31:0]     s_act_psum = '0;
    logic [IDW-1:0]  s_act_id = '0;
    logic [IDW-1:0]  bus_id;
    logic            bus_flush_kernel;
    logic [7:0]      bus_kernel_size;
    logic [15:0]     bus_fltr_data;
    logic            bus_fltr_we;
    logic [15:0]     bus_ifmap_data;
    logic [31:0]     bus_psum_data;
    logic            bus_data_valid;
    logic            bus_kernel_busy = 1'b0;
    logic            bus_ready = 1'b0;
    logic            kernel_loaded;
    logic            cfg_err;
    logic [15:0]     act_count;

    int checks = 0;
    int failures = 0;

    mc_bus_dispatcher dut (
        .clk(clk), .rst(rst),
        .s_kcfg_valid(s_kcfg_valid), .s_kcfg_ready(s_kcfg_ready),
        .s_kcfg_size(s_kcfg_size), .s_kcfg_id(s_kcfg_id),
        .s_fltr_valid(s_fltr_valid), .s_fltr_ready(s_fltr_ready),
        .s_fltr_data(s_fltr_data),
        .s_act_valid(s_act_valid), .s_act_ready(s_act_ready),
        .s_act_ifmap(s_act_ifmap), .s_act_psum(s_act_psum),
        .s_act_id(s_act_id),
        .bus_id(bus_id), .bus_flush_kernel(bus_flush_kernel),
        .bus_kernel_size(bus_kernel_size), .bus_fltr_data(bus_fltr_data),
        .bus_fltr_we(bus_fltr_we), .bus_ifmap_data(bus_ifmap_data),
        .bus_psum_data(bus_psum_data), .bus_data_valid(bus_data_valid),
        .bus_kernel_busy(bus_kernel_busy), .bus_ready(bus_ready),
        .kernel_loaded(kernel_loaded), .cfg_err(cfg_err),
        .act_count(act_count)
    );

    always #5 clk = ~clk;

    // Model: a pending flush, a count of weights still owed, a settle
    // window after the last weight, and the events expected on the bus.
    logic        m_flushing = 0, m_settle = 0, m_guard = 0;
    logic        m_loaded = 0, m_err = 0;
    int          m_left = 0;
    logic [7:0]  m_size = '0;
    logic [15:0] m_cnt = '0;
    logic        e_flush = 0, e_we = 0, e_dv = 0;
    logic [2:0]  e_id = '0;
    logic [7:0]  e_ksize = '0;
    logic [15:0] e_fd = '0, e_if = '0;
    logic [31:0] e_ps = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flushing <= 0; m_settle <= 0; m_guard <= 0;
            m_loaded <= 0; m_err <= 0; m_left <= 0; m_size <= '0;
            m_cnt <= '0; e_flush <= 0; e_we <= 0; e_dv <= 0;
            e_id <= '0; e_ksize <= '0; e_fd <= '0; e_if <= '0; e_ps <= '0;
        end else begin
            e_flush <= 0; e_we <= 0; e_dv <= 0;
            if (m_flushing) begin
                m_flushing <= 0;
                m_left <= int'(m_size);
            end else if (m_left > 0) begin
                if (s_fltr_valid) begin
                    e_we <= 1; e_fd <= s_fltr_data;
                    m_left <= m_left - 1;
                    if (m_left == 1) begin m_settle <= 1; m_guard <= 1; end
                end
            end else if (m_settle) begin
                if (m_guard) m_guard <= 0;
                else if (!bus_kernel_busy) begin m_settle <= 0; m_loaded <= 1; end
            end else if (s_kcfg_valid) begin
                if (s_kcfg_size >= 1 && s_kcfg_size <= 16) begin
                    m_flushing <= 1; m_size <= s_kcfg_size;
                    e_flush <= 1; e_ksize <= s_kcfg_size; e_id <= s_kcfg_id;
                    m_loaded <= 0; m_cnt <= '0;
                end else begin
                    m_err <= 1;
                end
            end else if (s_act_valid && m_loaded && bus_ready) begin
                e_dv <= 1; e_id <= s_act_id;
                e_if <= s_act_ifmap; e_ps <= s_act_psum;
                m_cnt <= m_cnt + 16'd1;
            end
        end
    end

    // Per-cycle comparison and observed-event bookkeeping.
    logic [15:0] we_q[$];
    int          n_flush = 0, n_dv = 0;
    logic [7:0]  last_fsize = '0;
    logic [2:0]  last_fid = '0;

    always @(negedge clk) begin
        logic idle;
        logic [7:0] c_dut, c_exp;
        logic [98:0] d_dut, d_exp;
        idle  = !m_flushing && m_left == 0 && !m_settle;
        c_dut = {s_kcfg_ready, s_fltr_ready, s_act_ready, bus_flush_kernel,
                 bus_fltr_we, bus_data_valid, kernel_loaded, cfg_err};
        c_exp = {!rst && idle, !rst && m_left > 0,
                 !rst && idle && m_loaded && bus_ready && !s_kcfg_valid,
                 e_flush, e_we, e_dv, m_loaded, m_err};
        d_dut = {bus_id, bus_kernel_size, bus_fltr_data, bus_ifmap_data,
                 bus_psum_data, act_count};
        d_exp = {e_id, e_ksize, e_fd, e_if, e_ps, m_cnt};
        checks++;
        if (c_dut !== c_exp) begin
            failures++;
            $display("FAIL ctl t=%0t got=%b exp=%b", $time, c_dut, c_exp);
        end
        checks++;
        if (d_dut !== d_exp) begin
            failures++;
            $display("FAIL data t=%0t got=%h exp=%h", $time, d_dut, d_exp);
        end
        if (bus_fltr_we) we_q.push_back(bus_fltr_data);
        if (bus_data_valid) n_dv++;
        if (bus_flush_kernel) begin
            n_flush++; last_fsize = bus_kernel_size; last_fid = bus_id;
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for one handshake on channel w (0 cfg, 1 fltr, 2 act), bounded.
    task automatic wait_hs(input int w, input string name);
        logic r;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            r = (w == 0) ? s_kcfg_ready : (w == 1) ? s_fltr_ready : s_act_ready;
            @(posedge clk);
            #1;
            if (r) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_%s got=no_handshake exp=handshake", name);
    endtask

    task automatic do_cfg(input logic [7:0] sz, input logic [2:0] id);
        s_kcfg_valid = 1; s_kcfg_size = sz; s_kcfg_id = id;
        wait_hs(0, "cfg");
        s_kcfg_valid = 0;
    endtask

    task automatic do_wts(input int n, input logic [15:0] base, input bit bub);
        for (int i = 0; i < n; i++) begin
            s_fltr_valid = 1; s_fltr_data = base + 16'(i);
            wait_hs(1, "fltr");
            if (bub && i == 2) begin s_fltr_valid = 0; cyc(1); end
        end
        s_fltr_valid = 0;
    endtask

    task automatic do_acts(input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            s_act_valid = 1; s_act_ifmap = base + 16'(k);
            s_act_psum = {16'hA5A5, base + 16'(k)}; s_act_id = 3'(k % 4);
            wait_hs(2, "act");
        end
        s_act_valid = 0;
    endtask

    initial begin
        cyc(3);
        @(negedge clk);
        chk("rst_loaded", kernel_loaded, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_count", act_count, 0);
        chk("rst_kcfg_ready", s_kcfg_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        bus_ready = 1;
        s_act_valid = 1; s_act_ifmap = 16'hDEAD;
        cyc(2);
        s_act_valid = 0;
        chk("unloaded_refused", n_dv, 0);

        // 1: kernel size 9 to column 2 with a source bubble
        bus_kernel_busy = 1;
        do_cfg(8'd9, 3'd2);
        do_wts(9, 16'h0001, 1);
        cyc(3);
        chk("t1_flush_cnt", n_flush, 1);
        chk("t1_flush_size", last_fsize, 9);
        chk("t1_flush_id", last_fid, 2);
        chk("t1_we_cnt", we_q.size(), 9);
        for (int i = 0; i < 9 && i < we_q.size(); i++)
            chk($sformatf("t1_we%0d", i), we_q[i], 16'(i + 1));
        chk("t1_busy_hold", kernel_loaded, 0);
        bus_kernel_busy = 0;
        cyc(3);
        chk("t1_loaded", kernel_loaded, 1);

        // 2: five back-to-back pairs
        do_acts(5, 16'h0100);
        cyc(2);
        chk("t2_dv", n_dv, 5);
        chk("t2_count", act_count, 5);
        chk("t2_model_count", m_cnt, 5);

        // 3: bus_ready toggling 1010 while four pairs are offered
        begin
            int k = 0;
            for (int c = 0; c < 40 && k < 4; c++) begin
                logic r;
                bus_ready = (c % 2 == 0);
                s_act_valid = 1; s_act_ifmap = 16'h0200 + 16'(k);
                s_act_psum = 32'h0003_0000 + 32'(k); s_act_id = 3'd1;
                @(negedge clk); r = s_act_ready;
                @(posedge clk); #1;
                if (r) k++;
            end
            s_act_valid = 0; bus_ready = 1;
            chk("t3_pairs", k, 4);
        end
        cyc(2);
        chk("t3_dv", n_dv, 9);
        chk("t3_count", act_count, 9);

        // 6: config and pair together; config wins
        s_act_valid = 1; s_act_ifmap = 16'hBEEF;
        do_cfg(8'd3, 3'd1);
        s_act_valid = 0;
        @(negedge clk);
        chk("t6_count_clr", act_count, 0);
        chk("t6_dv", n_dv, 9);
        @(posedge clk); #1;
        do_wts(3, 16'h0020, 0);
        cyc(4);
        chk("t6_loaded", kernel_loaded, 1);

        // 4: illegal sizes
        do_cfg(8'd0, 3'd1);
        do_cfg(8'd20, 3'd1);
        cyc(2);
        chk("t4_err", cfg_err, 1);
        chk("t4_flush_cnt", n_flush, 2);
        chk("t4_loaded", kernel_loaded, 1);

        // 5: reset after 4 of 9 weights
        bus_kernel_busy = 1;
        do_cfg(8'd9, 3'd3);
        do_wts(4, 16'h0040, 0);
        rst = 1;
        @(negedge clk);
        chk("t5_loaded", kernel_loaded, 0);
        chk("t5_bus", {bus_id, bus_flush_kernel, bus_kernel_size, bus_fltr_data,
            bus_fltr_we, bus_ifmap_data, bus_data_valid}, 0);
        chk("t5_psum", bus_psum_data, 0);
        @(posedge clk); #1;
        rst = 0;
        s_act_valid = 1; s_act_ifmap = 16'h0666;
        cyc(3);
        s_act_valid = 0;
        chk("t5_refused", n_dv, 9);
        bus_kernel_busy = 0;
        do_cfg(8'd2, 3'd0);
        do_wts(2, 16'h0050, 0);
        cyc(4);
        chk("t5_reloaded", kernel_loaded, 1);
        do_acts(2, 16'h0300);
        cyc(2);
        chk("t5_dv", n_dv, 11);
        chk("t5_count", act_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
